// File: rtl/biquad_coeff_loader.sv
// biquad_coeff_loader
// Collects a full set of DF2T biquad coefficients into a shadow bank, then
// swaps the set into the active registers on a sample boundary, so the filter
// never runs with a mix of old and new coefficients.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   cfg_valid/ready   coefficient write handshake (ready is low while PENDING)
//   cfg_addr          0=b0 1=b1 2=b2 3=a1 4=a2, 5-7 illegal
//   cfg_data          signed coefficient value
//   cfg_commit        request a swap of the shadow bank (qualified by ready)
//   cfg_err_clr       clears cfg_err (a same-cycle error event still sets)
//   sample_tick       one-cycle strobe at the biquad input-sample boundary
//   b0,b1,b2,a1,a2    active coefficients, registered
//   swap_done         one-cycle pulse once the active bank holds the new set
//   busy              high while a committed set waits for a tick
//   cfg_err           sticky: [0] illegal address / incomplete commit,
//                     [1] swap forced by timeout
module biquad_coeff_loader #(
  parameter int COEFF_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [2:0]                    cfg_addr,
  input  logic signed [COEFF_WIDTH-1:0] cfg_data,
  input  logic                          cfg_commit,
  input  logic                          cfg_err_clr,
  input  logic                          sample_tick,
  output logic signed [COEFF_WIDTH-1:0] b0,
  output logic signed [COEFF_WIDTH-1:0] b1,
  output logic signed [COEFF_WIDTH-1:0] b2,
  output logic signed [COEFF_WIDTH-1:0] a1,
  output logic signed [COEFF_WIDTH-1:0] a2,
  output logic                          swap_done,
  output logic                          busy,
  output logic [1:0]                    cfg_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PENDING} state_t;

  state_t                        state, state_nxt;
  logic [4:0]                    mask, mask_upd;
  logic signed [COEFF_WIDTH-1:0] shadow [5];
  logic [CNT_W-1:0]              cnt;

  logic wr_acc, wr_legal, wr_illegal;
  logic commit_acc, commit_ok, commit_bad;
  logic tick_swap, timeout_swap, do_swap;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (commit_ok)     state_nxt = PENDING;
        else if (wr_legal) state_nxt = LOAD;
      end
      LOAD: begin
        if (commit_ok) state_nxt = PENDING;
      end
      PENDING: begin
        if (do_swap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output and strobe decode. A same-cycle legal write is folded into
  // mask_upd so the commit completeness check sees it.
  always_comb begin
    cfg_ready  = (state != PENDING);
    busy       = (state == PENDING);
    wr_acc     = cfg_valid && cfg_ready;
    wr_legal   = wr_acc && (cfg_addr <= 3'd4);
    wr_illegal = wr_acc && (cfg_addr > 3'd4);
    mask_upd   = mask;
    for (int i = 0; i < 5; i++) begin
      if (wr_legal && (cfg_addr == 3'(i))) mask_upd[i] = 1'b1;
    end
    commit_acc   = cfg_commit && cfg_ready;
    commit_ok    = commit_acc && (mask_upd == 5'b11111);
    commit_bad   = commit_acc && !commit_ok;
    // A tick arriving together with the timeout is treated as a normal swap.
    tick_swap    = busy && sample_tick;
    timeout_swap = busy && !sample_tick && (cnt == CNT_LAST);
    do_swap      = tick_swap || timeout_swap;
  end

  // Shadow bank, write mask and PENDING timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
      cnt  <= '0;
      for (int i = 0; i < 5; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (wr_legal && (cfg_addr == 3'(i))) shadow[i] <= cfg_data;
      end
      if (do_swap) mask <= '0;
      else         mask <= mask_upd;
      if (commit_ok) cnt <= '0;
      else if (busy) cnt <= cnt + 1'b1;
    end
  end

  // Active bank, swap pulse and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b0        <= '0;
      b1        <= '0;
      b2        <= '0;
      a1        <= '0;
      a2        <= '0;
      swap_done <= 1'b0;
      cfg_err   <= 2'b00;
    end else begin
      if (do_swap) begin
        b0 <= shadow[0];
        b1 <= shadow[1];
        b2 <= shadow[2];
        a1 <= shadow[3];
        a2 <= shadow[4];
      end
      swap_done <= do_swap;
      // Clear first, then OR in this cycle's events so a set wins over clear.
      cfg_err <= (cfg_err_clr ? 2'b00 : cfg_err) |
                 {timeout_swap, (wr_illegal || commit_bad)};
    end
  end

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// tb_biquad_coeff_loader
// Self-checking bench for biquad_coeff_loader with TIMEOUT_CYCLES=8. A small
// behavioural model tracks the shadow bank, mask, pending state and errors;
// each expected swap pushes the model's shadow bank onto a queue that is
// popped whenever the DUT pulses swap_done.
module tb_biquad_coeff_loader;

  localparam int W  = 16;
  localparam int TO = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [2:0]          cfg_addr = '0;
  logic signed [W-1:0] cfg_data = '0;
  logic                cfg_commit = 1'b0;
  logic                cfg_err_clr = 1'b0;
  logic                sample_tick = 1'b0;
  logic signed [W-1:0] b0, b1, b2, a1, a2;
  logic                swap_done;
  logic                busy;
  logic [1:0]          cfg_err;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_sh [5];
  logic [4:0]   m_mask = '0;
  bit           m_pend = 1'b0;
  int           m_cnt = 0;
  logic [1:0]   m_err = '0;
  logic [5*W-1:0] exp_q [$];
  logic [5*W-1:0] prev_act = '0;

  wire [5*W-1:0] act = {b0, b1, b2, a1, a2};

  biquad_coeff_loader #(.COEFF_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_err_clr(cfg_err_clr), .sample_tick(sample_tick),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
    .swap_done(swap_done), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [5*W-1:0] got,
                             input logic [5*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 5; i++) m_sh[i] = '0;
    m_mask = '0;
    m_pend = 1'b0;
    m_cnt  = 0;
    m_err  = '0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check
  // the handshake/status outputs just after the edge.
  task automatic applyStimulus(input bit v, input logic [2:0] a,
                               input logic [W-1:0] d, input bit c,
                               input bit t, input bit clr);
    bit sw;
    logic [1:0] set;
    sw  = 1'b0;
    set = 2'b00;
    cfg_valid = v; cfg_addr = a; cfg_data = d;
    cfg_commit = c; sample_tick = t; cfg_err_clr = clr;
    if (!m_pend) begin
      if (v) begin
        if (a <= 3'd4) begin
          m_sh[int'(a)]   = d;
          m_mask[int'(a)] = 1'b1;
        end else set[0] = 1'b1;
      end
      if (c) begin
        if (m_mask == 5'b11111) begin
          m_pend = 1'b1;
          m_cnt  = 0;
        end else set[0] = 1'b1;
      end
    end else begin
      if (t || m_cnt == TO - 1) begin
        sw = 1'b1;
        if (!t) set[1] = 1'b1;
        exp_q.push_back({m_sh[0], m_sh[1], m_sh[2], m_sh[3], m_sh[4]});
        m_pend = 1'b0;
        m_mask = '0;
      end else m_cnt++;
    end
    m_err = (clr ? 2'b00 : m_err) | set;
    @(posedge clk);
    #1;
    checkOutput("busy", {79'b0, busy}, {79'b0, m_pend});
    checkOutput("cfg_ready", {79'b0, cfg_ready}, {79'b0, !m_pend});
    checkOutput("cfg_err", {78'b0, cfg_err}, {78'b0, m_err});
    checkOutput("swap_done", {79'b0, swap_done}, {79'b0, sw});
    cfg_valid = 1'b0; cfg_commit = 1'b0; sample_tick = 1'b0; cfg_err_clr = 1'b0;
  endtask

  task automatic writeAll(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3,
                          input logic [W-1:0] d4);
    applyStimulus(1, 3'd0, d0, 0, 0, 0);
    applyStimulus(1, 3'd1, d1, 0, 0, 0);
    applyStimulus(1, 3'd2, d2, 0, 0, 0);
    applyStimulus(1, 3'd3, d3, 0, 0, 0);
    applyStimulus(1, 3'd4, d4, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 3'd0, '0, 0, 0, 0);
  endtask

  // Scoreboard pop on swap_done; otherwise the active bank must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_act = act;
    end else begin
      if (swap_done) begin
        if (exp_q.size() == 0) checkOutput("swap_unexpected", {79'b0, swap_done}, '0);
        else                   checkOutput("active_bank", act, exp_q.pop_front());
      end else begin
        checkOutput("active_hold", act, prev_act);
      end
      prev_act = act;
    end
  end

  initial begin
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_active", act, '0);
    checkOutput("rst_swap_done", {79'b0, swap_done}, '0);
    checkOutput("rst_busy", {79'b0, busy}, '0);
    checkOutput("rst_err", {78'b0, cfg_err}, '0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_ready", {79'b0, cfg_ready}, {79'b0, 1'b1});

    // Full load, commit, tick after a few pending cycles.
    writeAll(16'h4000, 16'h8000, 16'h4000, 16'hA000, 16'h3000);
    applyStimulus(0, 3'd0, '0, 1, 0, 0);
    idle(5);
    checkOutput("t1_pre_tick", act, '0);
    applyStimulus(0, 3'd0, '0, 0, 1, 0);
    checkOutput("t1_coeffs", act, {16'h4000, 16'h8000, 16'h4000, 16'hA000, 16'h3000});
    idle(1);

    // Incomplete commit errors and keeps LOAD; completing it then swaps.
    applyStimulus(1, 3'd0, 16'h1111, 0, 0, 0);
    applyStimulus(1, 3'd1, 16'h2222, 0, 0, 0);
    applyStimulus(1, 3'd2, 16'h3333, 0, 0, 0);
    applyStimulus(1, 3'd3, 16'h4444, 0, 0, 0);
    applyStimulus(0, 3'd0, '0, 1, 0, 0);
    checkOutput("t2_err", {78'b0, cfg_err}, {78'b0, 2'b01});
    checkOutput("t2_unchanged", act, {16'h4000, 16'h8000, 16'h4000, 16'hA000, 16'h3000});
    applyStimulus(1, 3'd4, 16'h5555, 0, 0, 0);
    applyStimulus(0, 3'd0, '0, 1, 0, 0);
    applyStimulus(0, 3'd0, '0, 0, 1, 0);
    checkOutput("t2_b0", {64'b0, b0}, {64'b0, 16'h1111});
    applyStimulus(0, 3'd0, '0, 0, 0, 1);

    // Writes held during PENDING are stalled, then accepted after the swap.
    writeAll(16'h0A0A, 16'h0B0B, 16'h1111, 16'h0C0C, 16'h0D0D);
    applyStimulus(0, 3'd0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 3'd2, 16'h1234, 0, 0, 0);
    applyStimulus(1, 3'd2, 16'h1234, 0, 1, 0);
    checkOutput("t3_b2_old", {64'b0, b2}, {64'b0, 16'h1111});
    applyStimulus(1, 3'd2, 16'h1234, 0, 0, 0);
    applyStimulus(1, 3'd0, 16'h0101, 0, 0, 0);
    applyStimulus(1, 3'd1, 16'h0202, 0, 0, 0);
    applyStimulus(1, 3'd3, 16'h0303, 0, 0, 0);
    applyStimulus(1, 3'd4, 16'h0404, 0, 0, 0);
    applyStimulus(0, 3'd0, '0, 1, 0, 0);
    applyStimulus(0, 3'd0, '0, 0, 1, 0);
    checkOutput("t3_b2_new", {64'b0, b2}, {64'b0, 16'h1234});

    // Forced swap after TO pending cycles, then error clear.
    writeAll(16'h7001, 16'h7002, 16'h7003, 16'h7004, 16'h7005);
    applyStimulus(0, 3'd0, '0, 1, 0, 0);
    idle(TO - 1);
    checkOutput("t4_still_busy", {79'b0, busy}, {79'b0, 1'b1});
    idle(1);
    checkOutput("t4_timeout_err", {78'b0, cfg_err}, {78'b0, 2'b10});
    checkOutput("t4_a2", {64'b0, a2}, {64'b0, 16'h7005});
    applyStimulus(0, 3'd0, '0, 0, 0, 1);
    checkOutput("t4_err_clr", {78'b0, cfg_err}, '0);
    // Tick on the timeout cycle is a normal swap.
    writeAll(16'h6001, 16'h6002, 16'h6003, 16'h6004, 16'h6005);
    applyStimulus(0, 3'd0, '0, 1, 0, 0);
    idle(TO - 1);
    applyStimulus(0, 3'd0, '0, 0, 1, 0);
    checkOutput("t4_tick_on_timeout_err", {78'b0, cfg_err}, '0);

    // Illegal address; set wins over clear; commit+tick same cycle waits.
    applyStimulus(1, 3'd6, 16'h7777, 0, 0, 0);
    checkOutput("t5_illegal", {78'b0, cfg_err}, {78'b0, 2'b01});
    applyStimulus(1, 3'd7, 16'h7777, 0, 0, 1);
    checkOutput("t5_set_wins", {78'b0, cfg_err}, {78'b0, 2'b01});
    applyStimulus(0, 3'd0, '0, 0, 0, 1);
    writeAll(16'h5001, 16'h5002, 16'h5003, 16'h5004, 16'h5005);
    applyStimulus(0, 3'd0, '0, 1, 1, 0);
    checkOutput("t5_no_early_swap", {79'b0, swap_done}, '0);
    idle(1);
    applyStimulus(0, 3'd0, '0, 0, 1, 0);
    checkOutput("t5_b1", {64'b0, b1}, {64'b0, 16'h5002});

    // Asynchronous reset in the middle of PENDING.
    writeAll(16'h0F01, 16'h0F02, 16'h0F03, 16'h0F04, 16'h0F05);
    applyStimulus(1, 3'd5, 16'h0, 0, 0, 0);
    applyStimulus(0, 3'd0, '0, 1, 0, 0);
    idle(2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_active_zero", act, '0);
    checkOutput("t6_busy", {79'b0, busy}, '0);
    checkOutput("t6_err", {78'b0, cfg_err}, '0);
    checkOutput("t6_swap_done", {79'b0, swap_done}, '0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 3'd0, '0, 1, 0, 0);
    checkOutput("t6_empty_commit_err", {78'b0, cfg_err}, {78'b0, 2'b01});
    idle(2);

    checkOutput("queue_empty", 80'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/biquad_coeff_loader.md
Name: biquad_coeff_loader

Overview:
- Upstream configuration stage for the DF2T biquad.
- Accepts coefficient writes over a valid/ready port into a shadow bank. On commit, it swaps the complete set into the active registers on a sample boundary, so the filter never runs a mix of old and new coefficients.
- Active outputs drive the biquad's b0, b1, b2, a1 and a2 inputs directly.

Parameters:
- COEFF_WIDTH, 16, width of each signed coefficient; matches the biquad COEFF_WIDTH.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait in PENDING for sample_tick before a forced swap; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cfg_valid  input  1  write request
- cfg_ready  output  1  loader can accept a write or commit
- cfg_addr  input  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5-7 illegal
- cfg_data  input  COEFF_WIDTH  signed coefficient value
- cfg_commit  input  1  request swap of the shadow bank; qualified by cfg_ready
- cfg_err_clr  input  1  clears cfg_err
- sample_tick  input  1  one-cycle strobe marking the biquad input-sample boundary
- b0, b1, b2, a1, a2  output  COEFF_WIDTH each  active coefficients, signed, registered
- swap_done  output  1  one-cycle pulse after the active bank is updated
- busy  output  1  high in PENDING
- cfg_err  output  2  sticky: [0] illegal address or incomplete commit; [1] timeout-forced swap

Behaviour:
- Reset (rst_n low, async): all outputs are 0 (active coefficients, swap_done, cfg_err, busy). Shadow registers, write mask and timeout counter are 0. State = IDLE. cfg_ready is 1 after reset release.
- State machine: IDLE (mask empty), LOAD (mask partially or fully set), PENDING (commit accepted, waiting for tick).
- cfg_ready = 1 in IDLE and LOAD, 0 in PENDING. busy = (state == PENDING).
- Write accepted when cfg_valid && cfg_ready.
  - Legal address: shadow[addr] <= cfg_data and mask[addr] <= 1.
  - Rewrites of the same address are allowed; the last one wins.
  - Illegal address (5-7): no shadow change; cfg_err[0] <= 1.
  - IDLE -> LOAD on the first legal write.
- Commit accepted when cfg_commit && cfg_ready.
  - A write in the same cycle is applied first and counts toward the mask.
  - Mask == 5'b11111: go to PENDING, clear the timeout counter.
  - Otherwise: cfg_err[0] <= 1, stay in the current state, keep shadow and mask.
- PENDING:
  - Counter increments every cycle.
  - sample_tick high: active <= shadow on that edge, so new values are visible the cycle after the tick. swap_done pulses that same cycle. Mask clears; go to IDLE.
  - Counter reaches TIMEOUT_CYCLES-1 without a tick: forced swap, identical to the tick case, plus cfg_err[1] <= 1.
  - A tick and a timeout in the same cycle count as a normal swap: no error.
- sample_tick outside PENDING is ignored. A tick in the same cycle a commit is accepted does not swap; the swap waits for the next tick.
- cfg_valid and cfg_commit in PENDING are not accepted. The initiator must hold them; there are no side effects.
- cfg_err_clr: cfg_err <= 0 in that cycle. If an error event occurs in the same cycle, the set wins.
- Active coefficients change only on a swap edge or at reset.
- Reset asserted mid-load or in PENDING: everything returns to reset values immediately. A partial shadow is discarded and active coefficients go to 0.
- No arithmetic. Data passes through bit-exact as signed COEFF_WIDTH; no saturation or resizing.

Test Plan:
- Write addr 0-4 = 0x4000, 0x8000, 0x4000, 0xA000, 0x3000; commit; tick 10 cycles later -> outputs unchanged (all 0) until the tick edge. Next cycle b0=0x4000, b1=0x8000, b2=0x4000, a1=0xA000, a2=0x3000; swap_done is one pulse; busy falls; cfg_err=0.
- Write only addr 0-3, then commit -> cfg_err=2'b01, state stays LOAD, outputs unchanged. Write addr 4, then commit -> PENDING; the next tick swaps.
- Commit, then hold cfg_valid with addr 2 = 0x1234 during PENDING -> cfg_ready=0 and not accepted. After the tick, active b2 equals the shadow value from before the commit. The held write is accepted the cycle after the swap.
- Commit with no tick, TIMEOUT_CYCLES=8 -> forced swap on the 8th PENDING cycle; swap_done pulses; cfg_err=2'b10. Pulse cfg_err_clr -> cfg_err=0.
- Write addr 6 -> cfg_err[0]=1 and no shadow change. Commit and tick in the same cycle with a full mask -> no swap until the next tick.
- Drop rst_n asynchronously mid-PENDING, between clock edges -> all outputs 0 immediately. After release, a commit errors because the mask is empty.
